// File: rtl/discrete_values_loader.sv
// discrete_values_loader
// Turns one packet per variable (index, choice count, then start/end pairs)
// into writes of the discrete-values range table. It also writes the
// per-variable choice count. Pairs given with start > end are stored in
// ascending order, and that event is remembered in a sticky error flag.
module discrete_values_loader #(
  parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = 8,
  parameter int MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 8,
  parameter int MAX_BIT_WIDTH_OF_DISCRETE_CHOICES = 4,
  localparam int W = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE,
  localparam int V = MAX_BIT_WIDTH_OF_VARIABLES_INDEX,
  localparam int C = MAX_BIT_WIDTH_OF_DISCRETE_CHOICES
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           out_ready,
  input  logic           in_abort,
  output logic           out_wr_en,
  output logic [V+C-1:0] out_wr_addr,
  output logic [2*W-1:0] out_wr_data,
  output logic           out_count_wr_en,
  output logic [V-1:0]   out_count_var,
  output logic [C:0]     out_count_value,
  output logic           out_done,
  output logic           out_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_START,
    S_END,
    S_DONE
  } state_t;

  localparam logic [C-1:0] CNT_ONE = C'(1);
  localparam logic [C:0]   VAL_ONE = (C+1)'(1);

  // Puts a (start, end) pair into ascending order for the table entry.
  function automatic logic [2*W-1:0] order_pair(input logic [W-1:0] lo_word,
                                                input logic [W-1:0] hi_word);
    if (lo_word > hi_word) begin
      order_pair = {hi_word, lo_word};
    end else begin
      order_pair = {lo_word, hi_word};
    end
  endfunction

  // Choice count reported to the randomizer: last index + 1, widened so a
  // full set of 2^C choices does not wrap to zero.
  function automatic logic [C:0] choice_count(input logic [C-1:0] last_idx);
    choice_count = {1'b0, last_idx} + VAL_ONE;
  endfunction

  // Control state
  state_t         state_q, state_d;
  logic [C-1:0]   cnt_q, cnt_d;

  // Packet fields captured from the stream
  logic [V-1:0]   var_q;
  logic [C-1:0]   last_q;
  logic [W-1:0]   start_q;
  logic           var_ld, last_ld, start_ld;

  // Registered outputs
  logic           wr_en_q, wr_en_d;
  logic [V+C-1:0] wr_addr_q, wr_addr_d;
  logic [2*W-1:0] wr_data_q, wr_data_d;
  logic           cnt_wr_en_q, cnt_wr_en_d;
  logic [V-1:0]   count_var_q, count_var_d;
  logic [C:0]     count_value_q, count_value_d;
  logic           done_q, done_d;
  logic           error_q, error_d;

  // Ready is low during the single DONE cycle, and while reset is held.
  assign out_ready = reset_n && (state_q != S_DONE);

  // Next-state, table-write and count-write decisions for each stream word.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    var_ld        = 1'b0;
    last_ld       = 1'b0;
    start_ld      = 1'b0;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    cnt_wr_en_d   = 1'b0;
    count_var_d   = count_var_q;
    count_value_d = count_value_q;
    done_d        = 1'b0;
    error_d       = error_q;

    if (in_abort) begin
      // Abort beats any accept in the same cycle; the partial packet is dropped.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            var_ld  = 1'b1;
            state_d = S_COUNT;
          end
        end
        S_COUNT: begin
          if (in_valid) begin
            last_ld = 1'b1;
            cnt_d   = '0;
            state_d = S_START;
          end
        end
        S_START: begin
          if (in_valid) begin
            start_ld = 1'b1;
            state_d  = S_END;
          end
        end
        S_END: begin
          if (in_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {var_q, cnt_q};
            wr_data_d = order_pair(start_q, in_data);
            if (start_q > in_data) begin
              error_d = 1'b1;
            end
            if (cnt_q == last_q) begin
              cnt_wr_en_d   = 1'b1;
              count_var_d   = var_q;
              count_value_d = choice_count(last_q);
              done_d        = 1'b1;
              state_d       = S_DONE;
            end else begin
              cnt_d   = cnt_q + CNT_ONE;
              state_d = S_START;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, choice counter and all visible outputs; cleared by reset at any time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      cnt_wr_en_q   <= 1'b0;
      count_var_q   <= '0;
      count_value_q <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      cnt_wr_en_q   <= cnt_wr_en_d;
      count_var_q   <= count_var_d;
      count_value_q <= count_value_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  // Packet field capture; these are always reloaded before use, so no reset.
  always_ff @(posedge clk) begin
    if (var_ld) begin
      var_q <= in_data[V-1:0];
    end
    if (last_ld) begin
      last_q <= in_data[C-1:0];
    end
    if (start_ld) begin
      start_q <= in_data;
    end
  end

  assign out_wr_en       = wr_en_q;
  assign out_wr_addr     = wr_addr_q;
  assign out_wr_data     = wr_data_q;
  assign out_count_wr_en = cnt_wr_en_q;
  assign out_count_var   = count_var_q;
  assign out_count_value = count_value_q;
  assign out_done        = done_q;
  assign out_error       = error_q;

endmodule

// File: tb/tb_discrete_values_loader.sv
// Randomized scoreboard bench for discrete_values_loader (W=8, V=8, C=4).
module tb_discrete_values_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        out_ready;
  logic        in_abort;
  logic        out_wr_en;
  logic [11:0] out_wr_addr;
  logic [15:0] out_wr_data;
  logic        out_count_wr_en;
  logic [7:0]  out_count_var;
  logic [4:0]  out_count_value;
  logic        out_done;
  logic        out_error;

  discrete_values_loader #(
    .MAX_BIT_WIDTH_OF_INTEGER_VARIABLE(8),
    .MAX_BIT_WIDTH_OF_VARIABLES_INDEX(8),
    .MAX_BIT_WIDTH_OF_DISCRETE_CHOICES(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .out_ready(out_ready),
    .in_abort(in_abort),
    .out_wr_en(out_wr_en),
    .out_wr_addr(out_wr_addr),
    .out_wr_data(out_wr_data),
    .out_count_wr_en(out_count_wr_en),
    .out_count_var(out_count_var),
    .out_count_value(out_count_value),
    .out_done(out_done),
    .out_error(out_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
    int          cyc;
    logic        err;
  } wr_t;

  typedef struct {
    logic [7:0] vidx;
    logic [4:0] val;
  } cnt_t;

  wr_t  wr_q[$];
  cnt_t cnt_q[$];

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;
  int counts_seen = 0;
  logic err_model = 1'b0;
  logic [11:0] last_addr = '0;
  logic [15:0] last_data = '0;
  logic [7:0] ps[16];
  logic [7:0] pe[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write/count strobe is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_wr_en) begin
        wr_t e;
        writes_seen++;
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", out_wr_addr, out_wr_data);
        end else begin
          e = wr_q.pop_front();
          check("wr_addr", 32'(out_wr_addr), 32'(e.addr));
          check("wr_data", 32'(out_wr_data), 32'(e.data));
          check("wr_latency_cycle", cyc, e.cyc);
          check("error_flag", 32'(out_error), 32'(e.err));
        end
      end
      if (out_count_wr_en) begin
        cnt_t c;
        counts_seen++;
        if (cnt_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_count: var %0h value %0d with nothing expected", out_count_var, out_count_value);
        end else begin
          c = cnt_q.pop_front();
          check("count_var", 32'(out_count_var), 32'(c.vidx));
          check("count_value", 32'(out_count_value), 32'(c.val));
          check("done_with_count", 32'(out_done), 32'd1);
          check("ready_low_in_done", 32'(out_ready), 32'd0);
        end
      end else if (out_done) begin
        checks++;
        errors++;
        $display("FAIL done_without_count: out_done=1 out_count_wr_en=0");
      end
    end
  end

  // Offers one word, possibly with random idle gaps; returns the cycle of acceptance.
  task automatic send_word(input logic [7:0] d, input int gap, output int acyc, output int nstall);
    bit accepted;
    int tries;
    accepted = 1'b0;
    tries = 0;
    nstall = 0;
    acyc = 0;
    while (!accepted && tries < 200) begin
      @(negedge clk);
      if (gap > 0 && $urandom_range(99) < gap) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = d;
        if (out_ready) begin
          accepted = 1'b1;
          acyc = cyc;
        end else begin
          nstall++;
        end
      end
      @(posedge clk);
      tries++;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: word %0h not accepted within 200 cycles", d);
    end
  endtask

  // Sends a whole packet from ps/pe and records what the table should receive.
  task automatic send_packet(input logic [7:0] vidx, input int n, input int gap, input bit chk_stall);
    int acyc, st, tot, lo, hi;
    wr_t w;
    cnt_t c;
    tot = 0;
    send_word(vidx, gap, acyc, st);
    send_word(8'(n - 1), gap, acyc, st);
    tot += st;
    for (int i = 0; i < n; i++) begin
      send_word(ps[i], gap, acyc, st);
      tot += st;
      send_word(pe[i], gap, acyc, st);
      tot += st;
      lo = (ps[i] <= pe[i]) ? int'(ps[i]) : int'(pe[i]);
      hi = (ps[i] <= pe[i]) ? int'(pe[i]) : int'(ps[i]);
      if (ps[i] > pe[i]) err_model = 1'b1;
      w.addr = 12'(int'(vidx) * 16 + i);
      w.data = 16'(lo * 256 + hi);
      w.cyc  = acyc + 1;
      w.err  = err_model;
      wr_q.push_back(w);
      last_addr = w.addr;
      last_data = w.data;
    end
    c.vidx = vidx;
    c.val  = 5'(n);
    cnt_q.push_back(c);
    if (chk_stall) check("no_stall_in_packet", tot, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(out_ready), 0);
    check({tag, "_wr_en"}, 32'(out_wr_en), 0);
    check({tag, "_wr_addr"}, 32'(out_wr_addr), 0);
    check({tag, "_wr_data"}, 32'(out_wr_data), 0);
    check({tag, "_count_wr_en"}, 32'(out_count_wr_en), 0);
    check({tag, "_count_var"}, 32'(out_count_var), 0);
    check({tag, "_count_value"}, 32'(out_count_value), 0);
    check({tag, "_done"}, 32'(out_done), 0);
    check({tag, "_error"}, 32'(out_error), 0);
  endtask

  initial begin
    int acyc, st, ws, cs, n, gap;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_abort = 1'b0;
    in_data  = '0;

    // Power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 check_all_zero("por");
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("por_ready_after_release", 32'(out_ready), 1);

    // Single pair
    ps[0] = 8'h10; pe[0] = 8'h20;
    send_packet(8'h05, 1, 0, 1'b1);
    idle(2);

    // Full choice set, gap-free
    for (int i = 0; i < 16; i++) begin
      ps[i] = 8'(i);
      pe[i] = 8'(i + 1);
    end
    send_packet(8'h03, 16, 0, 1'b1);
    idle(2);

    // Swapped range, then a clean packet
    ps[0] = 8'h40; pe[0] = 8'h10;
    send_packet(8'h0A, 1, 0, 1'b1);
    idle(2);
    ps[0] = 8'h01; pe[0] = 8'h02;
    send_packet(8'h0B, 1, 0, 1'b1);
    idle(2);
    check("error_sticky_after_clean", 32'(out_error), 1);

    // Abort after the first START word of a 3-pair packet
    ws = writes_seen;
    cs = counts_seen;
    send_word(8'h09, 0, acyc, st);
    send_word(8'h02, 0, acyc, st);
    send_word(8'h11, 0, acyc, st);
    @(negedge clk);
    in_abort = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h22;
    @(negedge clk);
    in_abort = 1'b0;
    in_valid = 1'b0;
    idle(4);
    check("abort_no_write", writes_seen, ws);
    check("abort_no_count", counts_seen, cs);
    check("error_sticky_after_abort", 32'(out_error), 1);
    ps[0] = 8'h33; pe[0] = 8'h44;
    send_packet(8'h07, 1, 0, 1'b1);
    idle(2);

    // 4-pair packet with random gaps
    for (int i = 0; i < 4; i++) begin
      ps[i] = 8'($urandom);
      pe[i] = 8'($urandom);
    end
    send_packet(8'h21, 4, 40, 1'b0);
    idle(2);

    // Random packets
    for (int p = 0; p < 12; p++) begin
      n = $urandom_range(16, 1);
      gap = ($urandom_range(1) == 0) ? 0 : $urandom_range(35, 5);
      for (int i = 0; i < n; i++) begin
        ps[i] = 8'($urandom);
        pe[i] = 8'($urandom);
      end
      send_packet(8'($urandom), n, gap, gap == 0);
      idle($urandom_range(2));
    end
    idle(3);
    check("hold_wr_addr", 32'(out_wr_addr), 32'(last_addr));
    check("hold_wr_data", 32'(out_wr_data), 32'(last_data));

    // Reset in the middle of a packet
    send_word(8'h22, 0, acyc, st);
    send_word(8'h01, 0, acyc, st);
    send_word(8'h33, 0, acyc, st);
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1 check_all_zero("midrst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    err_model = 1'b0;
    #1 check("midrst_ready_after_release", 32'(out_ready), 1);
    ps[0] = 8'h01; pe[0] = 8'h02;
    ps[1] = 8'h05; pe[1] = 8'h06;
    send_packet(8'h44, 2, 0, 1'b1);
    idle(5);

    check("writes_all_seen", wr_q.size(), 0);
    check("counts_all_seen", cnt_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/discrete_values_loader.md
# discrete_values_loader

Streaming writer for the discrete-values range table used by the discrete range randomizer. It accepts one packet per variable over a valid/ready word stream: variable index, choice count, then (start, end) pairs. Each pair becomes a table write of `{start,end}` at address `{variable_index, choice_index}`. It also emits the per-variable choice count, so the randomizer knows how many table entries are valid.

## Interface

Parameters:
- MAX_BIT_WIDTH_OF_INTEGER_VARIABLE, 8, width W of stream words and of start/end values
- MAX_BIT_WIDTH_OF_VARIABLES_INDEX, 8, width V of a variable index; must be ≤ W
- MAX_BIT_WIDTH_OF_DISCRETE_CHOICES, 4, width C of a choice index; must be ≤ W

Ports:
- clk  in  1  single clock; everything is rising-edge
- reset_n  in  1  asynchronous, active-low reset
- in_data  in  W  stream word
- in_valid  in  1  in_data is valid
- out_ready  out  1  loader accepts a word this cycle
- in_abort  in  1  synchronous packet abort
- out_wr_en  out  1  one-cycle table write strobe
- out_wr_addr  out  V+C  `{variable_index, choice_index}`
- out_wr_data  out  2W  `{start, end}`
- out_count_wr_en  out  1  choice-count write strobe
- out_count_var  out  V  variable index of the count
- out_count_value  out  C+1  number of choices written (1 .. 2^C)
- out_done  out  1  one-cycle pulse at end of packet
- out_error  out  1  sticky flag: at least one pair had start > end

## Operation

- A word is accepted on a rising edge where in_valid && out_ready.
- Packet format:
  - word0: variable index, taken from bits [V-1:0].
  - word1: N-1, taken from bits [C-1:0]; N ranges 1 .. 2^C.
  - Then N pairs, each as start word followed by end word.
- FSM states: IDLE, COUNT, START, END, DONE.
  - IDLE: accept → latch var, go to COUNT.
  - COUNT: accept → latch last = in_data[C-1:0]; clear choice counter; go to START.
  - START: accept → latch start; go to END.
  - END: accept → register a write; if choice counter == last go to DONE, else increment counter and go to START.
  - DONE: lasts one cycle, then IDLE.
- out_ready = 1 in IDLE, COUNT, START and END; 0 in DONE and during reset.
- Range check: if start > end (unsigned), the entry is written swapped as `{end, start}` and out_error is set. out_error stays set until reset_n is asserted; in_abort does not clear it.
- Arithmetic:
  - Choice counter is C bits.
  - out_count_value = last + 1 computed at C+1 bits, so N = 2^C reports 2^C with no wrap.
- in_abort:
  - Takes priority over any accept in the same cycle.
  - Next state is IDLE.
  - A write already registered from an END accepted in the previous cycle still completes.
  - No out_count_wr_en and no out_done for the aborted packet.
- Reset (asynchronous, at any point including mid-packet):
  - State goes to IDLE.
  - All outputs go to 0: out_wr_en, out_wr_addr, out_wr_data, out_count_wr_en, out_count_var, out_count_value, out_done, out_error.
  - out_ready also reads 0 while reset_n is low and returns to 1 in the first cycle after release.
- in_data is ignored whenever it is not accepted.

## Timing

- All outputs are registered.
- END word accepted at edge k → out_wr_en, out_wr_addr and out_wr_data valid for exactly cycle k..k+1.
- Last END accepted at edge k → in the same cycle k..k+1:
  - out_wr_en, out_count_wr_en and out_done all high;
  - state is DONE and out_ready = 0.
- Back-to-back packets: IDLE is re-entered at edge k+1, so the next word0 can be accepted at edge k+2.
- Minimum packet time is 2+2N accepted words plus 1 DONE cycle.
- Throughput: one word per cycle with in_valid held high; no other stalls.
- out_wr_addr, out_wr_data, out_count_var and out_count_value hold their last values when the strobes are low.

## Test plan

- Reset: assert reset_n low mid-packet.
  - Required: all outputs 0 during reset; out_ready = 1 the cycle after release.
  - The next word is treated as word0.
- Single pair, W=8, C=4: words 0x05, 0x00, 0x10, 0x20.
  - Required: one write with addr = 0x050 and data = 0x1020.
  - In that same cycle: out_count_var = 5, out_count_value = 1, out_done = 1, out_ready = 0.
- Full choice set: var 3, N-1 = 15, sixteen pairs (i, i+1).
  - Required: 16 writes at addresses 0x030..0x03F; out_count_value = 16.
  - No other out_ready deassertion occurs.
- Swapped range: pair (0x40, 0x10).
  - Required: data written as 0x1040; out_error = 1.
  - out_error still 1 after a following clean packet and after in_abort.
- Abort: raise in_abort after the first pair's START word of a 3-pair packet.
  - Required: no write, no count write, no out_done.
  - The next packet (var 7, one pair) is written correctly at 0x070.
- Backpressure/gaps: randomly drop in_valid across a 4-pair packet.
  - Required: writes are identical to the gap-free run.
  - Each write follows its END accept by exactly 1 cycle.
